// File: rtl/demorgan_pkg.sv
// Shared types and the golden truth-table function for the demorgan sweep checker.
// Bit order of every 6-bit vector: [5]nA [4]nB [3]nAandnB [2]nAornB [1]AandB [0]AorB.
package demorgan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int ROWS = 4;

   localparam int ERR_NA      = 5;
   localparam int ERR_NB      = 4;
   localparam int ERR_NANDNB  = 3;
   localparam int ERR_NAORNB  = 2;
   localparam int ERR_AANDB   = 1;
   localparam int ERR_AORB    = 0;

   function automatic logic [5:0] golden(input logic a, input logic b);
      logic [5:0] v;
      v             = '0;
      v[ERR_NA]     = ~a;
      v[ERR_NB]     = ~b;
      v[ERR_NANDNB] = ~a & ~b;
      v[ERR_NAORNB] = ~a | ~b;
      v[ERR_AANDB]  = ~(a & b);
      v[ERR_AORB]   = ~(a | b);
      return v;
   endfunction

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker (master) and the demorgan block (slave).
interface demorgan_sweep_checker_if;

   logic A;
   logic B;
   logic nA;
   logic nB;
   logic nAandnB;
   logic nAornB;
   logic AandB;
   logic AorB;

   modport master (
      output A, B,
      input  nA, nB, nAandnB, nAornB, AandB, AorB
   );

   modport slave (
      input  A, B,
      output nA, nB, nAandnB, nAornB, AandB, AorB
   );

endinterface

// File: rtl/demorgan_golden.sv
// Combinational reference for the demorgan block: maps the driven {A,B} row to the expected outputs.
module demorgan_golden
   import demorgan_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   output logic [5:0] expected_o
);

   assign expected_o = golden(a_i, b_i);

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps A/B through all four rows PASSES times, samples the demorgan outputs after a settle
// period and accumulates mismatch statistics against the golden model.
module demorgan_sweep_checker
   import demorgan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned PASSES        = 1
)
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   demorgan_sweep_checker_if.master        dm,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [7:0]                      err_count,
   output logic [5:0]                      err_vec,
   output logic [1:0]                      first_err_row,
   output logic                            first_err_valid
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] SWEEP_LAST  = 4'(PASSES - 1);
   localparam logic [1:0] ROW_LAST    = 2'(ROWS - 1);

   state_e      state_q, state_d;
   logic [1:0]  ab_q, ab_d;
   logic [3:0]  settleCnt_q, settleCnt_d;
   logic [3:0]  sweepCnt_q, sweepCnt_d;
   logic [7:0]  errCount_q, errCount_d;
   logic [5:0]  errVec_q, errVec_d;
   logic [1:0]  firstErrRow_q, firstErrRow_d;
   logic        firstErrValid_q, firstErrValid_d;
   logic        pass_q, pass_d;

   logic [5:0]  expected;
   logic [5:0]  observed;
   logic [5:0]  mism;
   logic        lastSample;

   demorgan_golden uGolden (
      .a_i        (ab_q[1]),
      .b_i        (ab_q[0]),
      .expected_o (expected)
   );

   assign observed   = {dm.nA, dm.nB, dm.nAandnB, dm.nAornB, dm.AandB, dm.AorB};
   assign mism       = observed ^ expected;
   assign lastSample = (ab_q == ROW_LAST) && (sweepCnt_q == SWEEP_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         ab_q            <= 2'b00;
         settleCnt_q     <= 4'd0;
         sweepCnt_q      <= 4'd0;
         errCount_q      <= 8'd0;
         errVec_q        <= 6'd0;
         firstErrRow_q   <= 2'b00;
         firstErrValid_q <= 1'b0;
         pass_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         ab_q            <= ab_d;
         settleCnt_q     <= settleCnt_d;
         sweepCnt_q      <= sweepCnt_d;
         errCount_q      <= errCount_d;
         errVec_q        <= errVec_d;
         firstErrRow_q   <= firstErrRow_d;
         firstErrValid_q <= firstErrValid_d;
         pass_q          <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = DRIVE;
         DRIVE:      if (settleCnt_q == SETTLE_LAST) state_d = SAMPLE;
         SAMPLE:     state_d = lastSample ? DONE : DRIVE;
         default:    state_d = IDLE;
      endcase
   end

   // Counters and result registers; the response is only looked at while in SAMPLE.
   always_comb begin
      ab_d            = ab_q;
      settleCnt_d     = settleCnt_q;
      sweepCnt_d      = sweepCnt_q;
      errCount_d      = errCount_q;
      errVec_d        = errVec_q;
      firstErrRow_d   = firstErrRow_q;
      firstErrValid_d = firstErrValid_q;
      pass_d          = pass_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ab_d            = 2'b00;
               settleCnt_d     = 4'd0;
               sweepCnt_d      = 4'd0;
               errCount_d      = 8'd0;
               errVec_d        = 6'd0;
               firstErrRow_d   = 2'b00;
               firstErrValid_d = 1'b0;
               pass_d          = 1'b0;
            end
         end
         DRIVE: begin
            settleCnt_d = settleCnt_q + 4'd1;
         end
         SAMPLE: begin
            if (mism != 6'd0) begin
               errCount_d = (errCount_q == 8'hFF) ? errCount_q : errCount_q + 8'd1;
               errVec_d   = errVec_q | mism;
               if (!firstErrValid_q) begin
                  firstErrRow_d   = ab_q;
                  firstErrValid_d = 1'b1;
               end
            end
            if (lastSample) begin
               pass_d = (errCount_d == 8'd0);
            end else begin
               ab_d        = ab_q + 2'd1;
               settleCnt_d = 4'd0;
               if (ab_q == ROW_LAST) sweepCnt_d = sweepCnt_q + 4'd1;
            end
         end
         default: begin
            ab_d = ab_q;
         end
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         DRIVE, SAMPLE: busy = 1'b1;
         DONE:          done = 1'b1;
         default:       busy = 1'b0;
      endcase
   end

   assign dm.A            = ab_q[1];
   assign dm.B            = ab_q[0];
   assign pass            = pass_q;
   assign err_count       = errCount_q;
   assign err_vec         = errVec_q;
   assign first_err_row   = firstErrRow_q;
   assign first_err_valid = firstErrValid_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: three checker instances with different SETTLE/PASSES settings,
// each watching a bench-side demorgan model with injectable stuck-at faults and off-sample noise.
module tb_demorgan_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst[3];
   logic       startSig[3];
   logic [5:0] stuck0[3];
   logic [5:0] stuck1[3];
   logic       corrupt[3];

   logic       busyW[3];
   logic       doneW[3];
   logic       passW[3];
   logic [7:0] cntW[3];
   logic [5:0] vecW[3];
   logic [1:0] rowW[3];
   logic       fevW[3];
   logic [1:0] abW[3];

   int settleTab[3] = '{1, 1, 3};
   int passTab[3]   = '{1, 2, 1};

   int testsRun  = 0;
   int failCount = 0;

   demorgan_sweep_checker_if ifc0 ();
   demorgan_sweep_checker_if ifc1 ();
   demorgan_sweep_checker_if ifc2 ();

   function automatic logic [5:0] refGood(input logic a, input logic b);
      return {~a, ~b, ~a & ~b, ~a | ~b, ~(a & b), ~(a | b)};
   endfunction

   // Bench-side demorgan: stuck-at masks applied, whole vector inverted while 'c' is set.
   function automatic logic [5:0] tbResp(input logic a, input logic b, input logic [5:0] s0,
                                         input logic [5:0] s1, input logic c);
      return ((refGood(a, b) & ~s0) | s1) ^ {6{c}};
   endfunction

   assign {ifc0.nA, ifc0.nB, ifc0.nAandnB, ifc0.nAornB, ifc0.AandB, ifc0.AorB} =
      tbResp(ifc0.A, ifc0.B, stuck0[0], stuck1[0], corrupt[0]);
   assign {ifc1.nA, ifc1.nB, ifc1.nAandnB, ifc1.nAornB, ifc1.AandB, ifc1.AorB} =
      tbResp(ifc1.A, ifc1.B, stuck0[1], stuck1[1], corrupt[1]);
   assign {ifc2.nA, ifc2.nB, ifc2.nAandnB, ifc2.nAornB, ifc2.AandB, ifc2.AorB} =
      tbResp(ifc2.A, ifc2.B, stuck0[2], stuck1[2], corrupt[2]);

   assign abW[0] = {ifc0.A, ifc0.B};
   assign abW[1] = {ifc1.A, ifc1.B};
   assign abW[2] = {ifc2.A, ifc2.B};

   demorgan_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1)) dut0 (
      .clk(clk), .reset(rst[0]), .start(startSig[0]), .dm(ifc0.master),
      .busy(busyW[0]), .done(doneW[0]), .pass(passW[0]), .err_count(cntW[0]),
      .err_vec(vecW[0]), .first_err_row(rowW[0]), .first_err_valid(fevW[0])
   );

   demorgan_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(2)) dut1 (
      .clk(clk), .reset(rst[1]), .start(startSig[1]), .dm(ifc1.master),
      .busy(busyW[1]), .done(doneW[1]), .pass(passW[1]), .err_count(cntW[1]),
      .err_vec(vecW[1]), .first_err_row(rowW[1]), .first_err_valid(fevW[1])
   );

   demorgan_sweep_checker #(.SETTLE_CYCLES(3), .PASSES(1)) dut2 (
      .clk(clk), .reset(rst[2]), .start(startSig[2]), .dm(ifc2.master),
      .busy(busyW[2]), .done(doneW[2]), .pass(passW[2]), .err_count(cntW[2]),
      .err_vec(vecW[2]), .first_err_row(rowW[2]), .first_err_valid(fevW[2])
   );

   typedef struct {
      int         inst;
      logic [5:0] s0;
      logic [5:0] s1;
      bit         noise;
      int         expCount;
      logic [5:0] expVec;
      logic [1:0] expRow;
      bit         expValid;
      bit         expPass;
   } vec_t;

   vec_t vecTab[6];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkResults(input int k, input int cnt, input logic [5:0] vec,
                               input logic [1:0] row, input bit fv, input bit ps);
      checkOutput($sformatf("err_count[%0d]", k), 32'(cntW[k]), 32'(cnt));
      checkOutput($sformatf("err_vec[%0d]", k), 32'(vecW[k]), 32'(vec));
      checkOutput($sformatf("first_err_row[%0d]", k), 32'(rowW[k]), 32'(row));
      checkOutput($sformatf("first_err_valid[%0d]", k), 32'(fevW[k]), 32'(fv));
      checkOutput($sformatf("pass[%0d]", k), 32'(passW[k]), 32'(ps));
   endtask

   task automatic checkReset(input int k);
      checkOutput($sformatf("rst_busy[%0d]", k), 32'(busyW[k]), 0);
      checkOutput($sformatf("rst_done[%0d]", k), 32'(doneW[k]), 0);
      checkOutput($sformatf("rst_ab[%0d]", k), 32'(abW[k]), 0);
      checkResults(k, 0, 6'd0, 2'b00, 1'b0, 1'b0);
   endtask

   // Expected results straight from the truth table: one count per bad row, OR of bad bits.
   task automatic refModel(input int passes, input logic [5:0] s0, input logic [5:0] s1,
                           output int cnt, output logic [5:0] vec, output logic [1:0] row,
                           output bit fv);
      logic [5:0] good;
      logic [5:0] m;
      logic [1:0] rr;
      cnt = 0; vec = '0; row = '0; fv = 1'b0;
      for (int p = 0; p < passes; p++) begin
         for (int r = 0; r < 4; r++) begin
            rr   = 2'(r);
            good = refGood(rr[1], rr[0]);
            m    = good ^ ((good & ~s0) | s1);
            if (m != 6'd0) begin
               if (cnt < 255) cnt++;
               vec = vec | m;
               if (!fv) begin
                  row = rr;
                  fv  = 1'b1;
               end
            end
         end
      end
   endtask

   // One full run: start pulse, per-cycle A/B/busy/done checks, optional extra start at againEdge.
   task automatic applyStimulus(input int k, input logic [5:0] s0, input logic [5:0] s1,
                                input bit noise, input int againEdge);
      int s;
      int total;
      int expAb;
      s     = settleTab[k];
      total = 4 * passTab[k] * (s + 1);
      @(negedge clk);
      stuck0[k]   = s0;
      stuck1[k]   = s1;
      corrupt[k]  = noise;
      startSig[k] = 1'b1;
      @(negedge clk);
      startSig[k] = 1'b0;
      checkOutput("clear_count", 32'(cntW[k]), 0);
      checkOutput("clear_vec", 32'(vecW[k]), 0);
      checkOutput("clear_valid", 32'(fevW[k]), 0);
      checkOutput("clear_done", 32'(doneW[k]), 0);
      checkOutput("start_busy", 32'(busyW[k]), 1);
      checkOutput("start_ab", 32'(abW[k]), 0);
      for (int e = 1; e <= total; e++) begin
         startSig[k] = (e == againEdge);
         corrupt[k]  = noise && ((e % (s + 1)) != 0);
         @(negedge clk);
         startSig[k] = 1'b0;
         expAb = (e < total) ? ((e / (s + 1)) % 4) : 3;
         checkOutput($sformatf("ab[%0d]@%0d", k, e), 32'(abW[k]), 32'(expAb));
         checkOutput($sformatf("done[%0d]@%0d", k, e), 32'(doneW[k]), 32'(e >= total));
         checkOutput($sformatf("busy[%0d]@%0d", k, e), 32'(busyW[k]), 32'(e < total));
      end
      corrupt[k] = 1'b0;
   endtask

   initial begin
      int         cnt;
      logic [5:0] vec;
      logic [1:0] row;
      bit         fv;
      logic [5:0] s0;
      logic [5:0] s1;
      bit         noise;
      int         k;

      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; startSig[i] = 1'b0; stuck0[i] = '0; stuck1[i] = '0; corrupt[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) checkReset(i);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;

      vecTab[0] = '{0, 6'b000000, 6'b000000, 1'b0, 0, 6'b000000, 2'b00, 1'b0, 1'b1};
      vecTab[1] = '{0, 6'b000001, 6'b000000, 1'b0, 1, 6'b000001, 2'b00, 1'b1, 1'b0};
      vecTab[2] = '{1, 6'b000100, 6'b000000, 1'b0, 6, 6'b000100, 2'b00, 1'b1, 1'b0};
      vecTab[3] = '{2, 6'b000000, 6'b000000, 1'b1, 0, 6'b000000, 2'b00, 1'b0, 1'b1};
      vecTab[4] = '{2, 6'b000000, 6'b100000, 1'b1, 2, 6'b100000, 2'b10, 1'b1, 1'b0};
      vecTab[5] = '{0, 6'b000000, 6'b111111, 1'b0, 3, 6'b111111, 2'b01, 1'b1, 1'b0};

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecTab[i].inst, vecTab[i].s0, vecTab[i].s1, vecTab[i].noise, -1);
         checkResults(vecTab[i].inst, vecTab[i].expCount, vecTab[i].expVec,
                      vecTab[i].expRow, vecTab[i].expValid, vecTab[i].expPass);
      end

      // Faulty run, then a clean run restarted from DONE with a stray start while busy.
      applyStimulus(0, 6'b000001, 6'b000000, 1'b0, -1);
      checkResults(0, 1, 6'b000001, 2'b00, 1'b1, 1'b0);
      applyStimulus(0, 6'b000000, 6'b000000, 1'b0, 3);
      checkResults(0, 0, 6'b000000, 2'b00, 1'b0, 1'b1);
      applyStimulus(0, 6'b000000, 6'b000000, 1'b0, -1);
      checkResults(0, 0, 6'b000000, 2'b00, 1'b0, 1'b1);

      // Reset at edge 5 of a faulty run, with start asserted on the same edge.
      @(negedge clk);
      stuck0[0]   = 6'b000001;
      startSig[0] = 1'b1;
      @(negedge clk);
      startSig[0] = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midrun_count", 32'(cntW[0]), 1);
      rst[0]      = 1'b1;
      startSig[0] = 1'b1;
      @(negedge clk);
      checkReset(0);
      rst[0]      = 1'b0;
      startSig[0] = 1'b0;
      applyStimulus(0, 6'b000000, 6'b000000, 1'b0, -1);
      checkResults(0, 0, 6'b000000, 2'b00, 1'b0, 1'b1);

      for (int i = 0; i < 9; i++) begin
         k     = i % 3;
         s0    = 6'($urandom);
         s1    = 6'($urandom) & ~s0;
         noise = 1'($urandom);
         refModel(passTab[k], s0, s1, cnt, vec, row, fv);
         applyStimulus(k, s0, s1, noise, -1);
         checkResults(k, cnt, vec, row, fv, cnt == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
